// File: rtl/sync_fifo_pkg.sv
// Shared defaults and read-mode encoding for the single-clock FIFO.
package sync_fifo_pkg;

   // Default geometry.
   localparam int DEF_DATA_WIDTH        = 32;
   localparam int DEF_ADDR_WIDTH        = 3;
   localparam int DEF_ALMOST_FULL_LEVEL = 6;

   // Read-mode encoding.
   localparam int SHOW_AHEAD_OFF = 0;   // q updates on the edge after rdreq
   localparam int SHOW_AHEAD_ON  = 1;   // head word presented without rdreq

endpackage

// File: rtl/sync_fifo_dp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// The q register clears on aclr; the storage array itself is never reset.
module dp_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  wrclock,
   input  logic                  rdclock,
   input  logic                  aclr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] wraddress,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] rdaddress,
   input  logic                  rden,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write port: store the word at wraddress when wren is high.
   always_ff @(posedge wrclock) begin
      if (wren) mem[wraddress] <= data;
   end

   // Read port: capture the addressed word when rden is high, hold otherwise.
   always_ff @(posedge rdclock or posedge aclr) begin
      if (aclr)      q <= '0;
      else if (rden) q <= mem[rdaddress];
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full threshold, sticky
// overflow/underflow flags and a selectable normal or show-ahead read port.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
   parameter int ALMOST_FULL_LEVEL = DEF_ALMOST_FULL_LEVEL,
   parameter int SHOW_AHEAD        = SHOW_AHEAD_OFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wrreq,
   input  logic                  rdreq,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   usedw,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_W    = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

   // Pointers carry a wrap bit and roll over modulo 2*DEPTH. rd_ptr is the
   // RAM fetch pointer: in show-ahead mode it runs ahead of the pop point by
   // the words held in the prefetch stages, so occupancy is tracked in usedw.
   logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
   logic                  wr_acc;    // write accepted this cycle
   logic                  pop;       // read accepted this cycle
   logic                  fetch;     // RAM read issued this cycle
   logic [DATA_WIDTH-1:0] ram_q;

   // full/almost_full come from the registered count. With usedw == DEPTH the
   // RAM never holds more than DEPTH unfetched words, so no slot is overwritten.
   assign full        = (usedw == DEPTH_W);
   assign almost_full = (usedw >= AF_W);
   assign wr_acc      = wrreq & ~full;
   assign pop         = rdreq & ~empty;

   dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .wrclock   (clk),
      .rdclock   (clk),
      .aclr      (1'b0),
      .data      (data),
      .wraddress (wr_ptr[ADDR_WIDTH-1:0]),
      .wren      (wrreq & ~full),
      .rdaddress (rd_ptr[ADDR_WIDTH-1:0]),
      .rden      (fetch),
      .q         (ram_q)
   );

   // Pointer and occupancy bookkeeping; a simultaneous write and pop leave usedw unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         usedw  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (fetch)  rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, pop})
            2'b10:   usedw <= usedw + 1'b1;
            2'b01:   usedw <= usedw - 1'b1;
            default: usedw <= usedw;
         endcase
      end
   end

   // Sticky error flags: set on any dropped request, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wrreq & full)  overflow  <= 1'b1;
         if (rdreq & empty) underflow <= 1'b1;
      end
   end

   if (SHOW_AHEAD == SHOW_AHEAD_OFF) begin : g_normal
      // The RAM read register is the output register. It is not reset, so q
      // is masked to zero until the first pop after reset.
      logic q_vld;

      assign fetch = pop;
      assign empty = (usedw == '0);
      assign q     = q_vld ? ram_q : '0;

      // Remember whether ram_q has been loaded since reset.
      always_ff @(posedge clk) begin
         if (rst)      q_vld <= 1'b0;
         else if (pop) q_vld <= 1'b1;
      end

   end else begin : g_show_ahead
      // Two-stage prefetch: stage 1 is the RAM read register (ram_q), stage 2
      // is q_reg. A word written into an empty FIFO is fetched one edge later
      // and lands in q_reg the edge after that. With both stages full a pop
      // moves stage 1 forward and refetches in the same cycle, sustaining one
      // read per clock.
      logic                  s1_vld, s2_vld;
      logic                  load;      // stage 1 -> stage 2 transfer
      logic                  ram_has;   // unfetched words remain in RAM
      logic [DATA_WIDTH-1:0] q_reg;

      assign ram_has = (rd_ptr != wr_ptr);
      assign load    = s1_vld & (~s2_vld | pop);
      assign fetch   = ram_has & (~s1_vld | load);
      assign empty   = ~s2_vld;
      assign q       = q_reg;

      // Prefetch stage valids and the show-ahead output register.
      always_ff @(posedge clk) begin
         if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            q_reg  <= '0;
         end else begin
            s1_vld <= fetch | (s1_vld & ~load);
            if (load) begin
               s2_vld <= 1'b1;
               q_reg  <= ram_q;
            end else if (pop) begin
               s2_vld <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: normal-mode FIFO for the bulk of the scenarios, a second
// show-ahead instance sharing the same inputs for the prefetch scenario.
module tb_sync_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] data = '0;
   logic        wrreq = 1'b0;
   logic        rdreq = 1'b0;

   logic [31:0] q, sa_q;
   logic        empty, full, almost_full, overflow, underflow;
   logic        sa_empty, sa_full, sa_almost_full, sa_overflow, sa_underflow;
   logic [3:0]  usedw, sa_usedw;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(6), .SHOW_AHEAD(0)) u_dut (
      .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .q(q), .empty(empty), .full(full), .almost_full(almost_full),
      .usedw(usedw), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(6), .SHOW_AHEAD(1)) u_sa (
      .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .rdreq(rdreq),
      .q(sa_q), .empty(sa_empty), .full(sa_full), .almost_full(sa_almost_full),
      .usedw(sa_usedw), .overflow(sa_overflow), .underflow(sa_underflow)
   );

   // Advance one edge; outputs are sampled 1 ns after it, inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 32'hFFFF_FFFF;
      tick();
      rst = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
      checks++; if (usedw !== 4'd0) begin errs++; $display("FAIL reset_usedw got=%0d exp=0", usedw); end
      checks++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%0b exp=1", empty); end
      checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errs++; $display("FAIL reset_full got=%0b/%0b exp=0/0", full, almost_full); end
      checks++; if (q !== 32'h0) begin errs++; $display("FAIL reset_q got=%0h exp=0", q); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errs++; $display("FAIL reset_flags got=%0b/%0b exp=0/0", overflow, underflow); end
      checks++; if (sa_empty !== 1'b1 || sa_q !== 32'h0) begin errs++; $display("FAIL reset_sa got=%0b/%0h exp=1/0", sa_empty, sa_q); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_q [3];
      exp_q[0] = 32'h11; exp_q[1] = 32'h22; exp_q[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         wrreq = 1'b1; data = exp_q[i];
         tick();
      end
      wrreq = 1'b0;
      checks++; if (usedw !== 4'd3) begin errs++; $display("FAIL basic_usedw got=%0d exp=3", usedw); end
      checks++; if (empty !== 1'b0) begin errs++; $display("FAIL basic_notempty got=%0b exp=0", empty); end
      for (int i = 0; i < 3; i++) begin
         rdreq = 1'b1;
         tick();
         checks++; if (q !== exp_q[i]) begin errs++; $display("FAIL basic_q%0d got=%0h exp=%0h", i, q, exp_q[i]); end
      end
      rdreq = 1'b0;
      tick();
      checks++; if (empty !== 1'b1 || usedw !== 4'd0) begin errs++; $display("FAIL basic_drained got=%0b/%0d exp=1/0", empty, usedw); end
      checks++; if (q !== 32'h33) begin errs++; $display("FAIL basic_qhold got=%0h exp=33", q); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         wrreq = 1'b1; data = 32'h100 + i;
         tick();
         checks++; if (almost_full !== (i + 1 >= 6)) begin errs++; $display("FAIL fill_af%0d got=%0b exp=%0b", i, almost_full, (i + 1 >= 6)); end
      end
      wrreq = 1'b0;
      checks++; if (full !== 1'b1 || usedw !== 4'd8) begin errs++; $display("FAIL fill_full got=%0b/%0d exp=1/8", full, usedw); end
      wrreq = 1'b1; rdreq = 1'b1; data = 32'hDEAD;
      tick();
      wrreq = 1'b0; rdreq = 1'b0;
      checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL fill_overflow got=%0b exp=1", overflow); end
      checks++; if (usedw !== 4'd7 || full !== 1'b0) begin errs++; $display("FAIL fill_after got=%0d/%0b exp=7/0", usedw, full); end
      checks++; if (q !== 32'h100) begin errs++; $display("FAIL fill_q0 got=%0h exp=100", q); end
      for (int i = 1; i < 8; i++) begin
         rdreq = 1'b1;
         tick();
         checks++; if (q !== 32'h100 + i) begin errs++; $display("FAIL fill_drain%0d got=%0h exp=%0h", i, q, 32'h100 + i); end
      end
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1) begin errs++; $display("FAIL fill_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_underflow();
      wrreq = 1'b1; rdreq = 1'b1; data = 32'hAA;
      tick();
      wrreq = 1'b0; rdreq = 1'b0;
      checks++; if (underflow !== 1'b1) begin errs++; $display("FAIL udf_flag got=%0b exp=1", underflow); end
      checks++; if (usedw !== 4'd1) begin errs++; $display("FAIL udf_usedw got=%0d exp=1", usedw); end
      checks++; if (q !== 32'h107) begin errs++; $display("FAIL udf_qhold got=%0h exp=107", q); end
      tick();
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      checks++; if (q !== 32'hAA || usedw !== 4'd0) begin errs++; $display("FAIL udf_read got=%0h/%0d exp=aa/0", q, usedw); end
      checks++; if (overflow !== 1'b1) begin errs++; $display("FAIL udf_ovf_sticky got=%0b exp=1", overflow); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) begin
         wrreq = 1'b1; data = 32'h200 + i;
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         wrreq = 1'b1; rdreq = 1'b1; data = 32'h204 + i;
         tick();
         checks++; if (q !== 32'h200 + i || usedw !== 4'd4) begin errs++; $display("FAIL wrap_%0d got=%0h/%0d exp=%0h/4", i, q, usedw, 32'h200 + i); end
      end
      wrreq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rdreq = 1'b1;
         tick();
         checks++; if (q !== 32'h214 + i) begin errs++; $display("FAIL wrap_drain%0d got=%0h exp=%0h", i, q, 32'h214 + i); end
      end
      rdreq = 1'b0;
      checks++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 9; i++) begin
         wrreq = 1'b1; data = 32'h300 + i;
         tick();
      end
      wrreq = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rdreq = 1'b1;
         tick();
      end
      rdreq = 1'b0;
      checks++; if (usedw !== 4'd5 || overflow !== 1'b1) begin errs++; $display("FAIL rmid_pre got=%0d/%0b exp=5/1", usedw, overflow); end
      rst = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 32'hBAD;
      tick();
      rst = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
      checks++; if (usedw !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errs++; $display("FAIL rmid_state got=%0d/%0b/%0b exp=0/1/0", usedw, empty, full); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0 || q !== 32'h0) begin errs++; $display("FAIL rmid_flags got=%0b/%0b/%0h exp=0/0/0", overflow, underflow, q); end
      wrreq = 1'b1; data = 32'h77;
      tick();
      wrreq = 1'b0; rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      checks++; if (q !== 32'h77 || empty !== 1'b1) begin errs++; $display("FAIL rmid_readback got=%0h/%0b exp=77/1", q, empty); end
   endtask

   task automatic test_show_ahead();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wrreq = 1'b1; data = 32'h55;
      tick();
      wrreq = 1'b0;
      checks++; if (sa_empty !== 1'b1 || sa_usedw !== 4'd1) begin errs++; $display("FAIL sa_n got=%0b/%0d exp=1/1", sa_empty, sa_usedw); end
      tick();
      tick();
      checks++; if (sa_empty !== 1'b0 || sa_q !== 32'h55) begin errs++; $display("FAIL sa_n2 got=%0b/%0h exp=0/55", sa_empty, sa_q); end
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      checks++; if (sa_empty !== 1'b1 || sa_usedw !== 4'd0) begin errs++; $display("FAIL sa_pop got=%0b/%0d exp=1/0", sa_empty, sa_usedw); end
      for (int i = 0; i < 3; i++) begin
         wrreq = 1'b1; data = 32'h61 + i;
         tick();
      end
      wrreq = 1'b0;
      tick();
      tick();
      checks++; if (sa_q !== 32'h61 || sa_empty !== 1'b0) begin errs++; $display("FAIL sa_head got=%0h/%0b exp=61/0", sa_q, sa_empty); end
      for (int i = 1; i < 3; i++) begin
         rdreq = 1'b1;
         tick();
         checks++; if (sa_q !== 32'h61 + i || sa_empty !== 1'b0) begin errs++; $display("FAIL sa_stream%0d got=%0h/%0b exp=%0h/0", i, sa_q, sa_empty, 32'h61 + i); end
      end
      tick();
      rdreq = 1'b0;
      checks++; if (sa_empty !== 1'b1 || sa_usedw !== 4'd0 || sa_underflow !== 1'b0) begin errs++; $display("FAIL sa_drain got=%0b/%0d/%0b exp=1/0/0", sa_empty, sa_usedw, sa_underflow); end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_fill();
      test_underflow();
      test_wrap();
      test_reset_mid();
      test_show_ahead();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
